// File: rtl/game_pkg.sv
// Shared types and helpers for the VGA board-game sprite blocks.
package game_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    BOUNCE = 1'b1
  } mode_t;

  localparam int GAME_SCREEN_W = 1280;
  localparam int GAME_SCREEN_H = 800;

  function automatic int clamp_coord(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-tick divider: registered one-cycle pulse every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 524288
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("tick_gen: TICK_DIV must be at least 2");
  end

  logic [CW-1:0] cnt;

  // tick is registered one cycle early so it is high while cnt == TICK_DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
      tick <= (cnt == CW'(TICK_DIV - 2));
    end
  end

endmodule

// File: rtl/sprite_ctrl.sv
// Single-sprite controller: tick-driven manual/bounce motion clamped to the
// screen, plus registered raster hit flags for the drawing pipeline.
module sprite_ctrl
  import game_pkg::*;
#(
  parameter int SCREEN_W = GAME_SCREEN_W,
  parameter int SCREEN_H = GAME_SCREEN_H,
  parameter int OBJ_W    = 140,
  parameter int OBJ_H    = 200,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 524288,
  parameter int START_X  = 520,
  parameter int START_Y  = 300,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_up,
  input  logic          in_down,
  input  logic          in_left,
  input  logic          in_right,
  input  logic          mode,
  input  logic          freeze,
  input  logic [XW-1:0] curr_x,
  input  logic [YW-1:0] curr_y,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          tick,
  output logic          hit,
  output logic          hit_lower
);

  localparam int XMAX = SCREEN_W - OBJ_W;
  localparam int YMAX = SCREEN_H - OBJ_H;
  localparam int MIN_RANGE = (XMAX < YMAX) ? XMAX : YMAX;

  localparam logic signed [XW:0] STEP_X = (XW+1)'(STEP);
  localparam logic signed [YW:0] STEP_Y = (YW+1)'(STEP);
  localparam logic signed [XW:0] XMAX_S = (XW+1)'(XMAX);
  localparam logic signed [YW:0] YMAX_S = (YW+1)'(YMAX);
  localparam logic [XW:0] OBJ_W_X  = (XW+1)'(OBJ_W);
  localparam logic [YW:0] OBJ_H_Y  = (YW+1)'(OBJ_H);
  localparam logic [YW:0] HALF_H_Y = (YW+1)'(OBJ_H / 2);

  if (OBJ_W < 1 || OBJ_W > SCREEN_W) begin : g_bad_obj_w
    $error("sprite_ctrl: OBJ_W out of range");
  end
  if (OBJ_H < 2 || OBJ_H > SCREEN_H) begin : g_bad_obj_h
    $error("sprite_ctrl: OBJ_H out of range");
  end
  if (STEP < 1 || (MIN_RANGE > 0 && STEP > MIN_RANGE)) begin : g_bad_step
    $error("sprite_ctrl: STEP out of range");
  end
  if (START_X < 0 || START_X > XMAX || START_Y < 0 || START_Y > YMAX) begin : g_bad_start
    $error("sprite_ctrl: start position outside clamp range");
  end
  if (SCREEN_W >= (1 << XW) || SCREEN_H >= (1 << YW)) begin : g_bad_width
    $error("sprite_ctrl: coordinate width too narrow for screen");
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  mode_t state;
  logic  dir_x, dir_y;

  logic signed [XW:0] sx, cand_x;
  logic signed [YW:0] sy, cand_y;
  logic [XW-1:0]      nx;
  logic [YW-1:0]      ny;
  logic               ndx, ndy, dx_eff, dy_eff;
  logic               in_x, in_y, in_lower;

  always_comb begin
    sx     = $signed({1'b0, pos_x});
    sy     = $signed({1'b0, pos_y});
    cand_x = sx;
    cand_y = sy;
    nx     = pos_x;
    ny     = pos_y;
    ndx    = dir_x;
    ndy    = dir_y;
    // entering bounce restarts both directions as +
    dx_eff = (state == BOUNCE) ? dir_x : 1'b1;
    dy_eff = (state == BOUNCE) ? dir_y : 1'b1;
    if (mode) begin
      cand_x = dx_eff ? sx + STEP_X : sx - STEP_X;
      cand_y = dy_eff ? sy + STEP_Y : sy - STEP_Y;
      ndx    = dx_eff;
      ndy    = dy_eff;
      if (cand_x > XMAX_S) begin
        nx  = XW'(XMAX);
        ndx = 1'b0;
      end else if (cand_x[XW]) begin
        nx  = '0;
        ndx = 1'b1;
      end else begin
        nx = cand_x[XW-1:0];
      end
      if (cand_y > YMAX_S) begin
        ny  = YW'(YMAX);
        ndy = 1'b0;
      end else if (cand_y[YW]) begin
        ny  = '0;
        ndy = 1'b1;
      end else begin
        ny = cand_y[YW-1:0];
      end
    end else begin
      if (in_right && !in_left) cand_x = sx + STEP_X;
      else if (in_left && !in_right) cand_x = sx - STEP_X;
      if (in_down && !in_up) cand_y = sy + STEP_Y;
      else if (in_up && !in_down) cand_y = sy - STEP_Y;
      nx = XW'(clamp_coord(int'(cand_x), XMAX));
      ny = YW'(clamp_coord(int'(cand_y), YMAX));
    end
  end

  always_comb begin
    in_x     = ({1'b0, curr_x} >= {1'b0, pos_x}) &&
               ({1'b0, curr_x} < {1'b0, pos_x} + OBJ_W_X);
    in_y     = ({1'b0, curr_y} >= {1'b0, pos_y}) &&
               ({1'b0, curr_y} < {1'b0, pos_y} + OBJ_H_Y);
    in_lower = ({1'b0, curr_y} >= {1'b0, pos_y} + HALF_H_Y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MANUAL;
      pos_x     <= XW'(START_X);
      pos_y     <= YW'(START_Y);
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      hit       <= 1'b0;
      hit_lower <= 1'b0;
    end else begin
      if (tick) begin
        state <= mode ? BOUNCE : MANUAL;
        if (!freeze) begin
          pos_x <= nx;
          pos_y <= ny;
          dir_x <= ndx;
          dir_y <= ndy;
        end
      end
      hit       <= in_x && in_y;
      hit_lower <= in_x && in_y && in_lower;
    end
  end

endmodule

// File: doc/sprite_ctrl.md
# sprite_ctrl

Parametrised game-object controller for the VGA board game: it owns one rectangular sprite's position, updates it on a divided game tick from button inputs (manual mode) or autonomous motion (bounce mode), and clamps the *whole* sprite inside the screen. It also produces registered per-pixel hit flags against the VGA raster coordinates, so the drawing pipeline can colour the sprite's upper and lower halves.

## Interface
Parameters:
- `SCREEN_W`, 1280: visible width in pixels.
- `SCREEN_H`, 800: visible height in pixels.
- `OBJ_W`, 140: sprite width; must satisfy 1 ≤ OBJ_W ≤ SCREEN_W.
- `OBJ_H`, 200: sprite height; must satisfy 2 ≤ OBJ_H ≤ SCREEN_H.
- `STEP`, 1: pixels moved per tick; must satisfy 1 ≤ STEP ≤ min(SCREEN_W−OBJ_W, SCREEN_H−OBJ_H) when that minimum is > 0.
- `TICK_DIV`, 524288: clock cycles per game tick; ≥ 2.
- `START_X`, 520 and `START_Y`, 300: reset position; must lie within the clamp range.
- `XW`, 11 and `YW`, 10: coordinate widths.

Ports:
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_up`, `in_down`, `in_left`, `in_right` in 1 each: button levels, already synchronised.
- `mode` in 1: 0 = MANUAL, 1 = BOUNCE; sampled only on a tick.
- `freeze` in 1: while 1, ticks still occur but position does not change.
- `curr_x` in XW, `curr_y` in YW: raster coordinate from vga_out.
- `pos_x` out XW, `pos_y` out YW: sprite top-left corner.
- `tick` out 1: one-cycle pulse per game tick.
- `hit` out 1: raster pixel is inside the sprite.
- `hit_lower` out 1: raster pixel is inside the sprite's lower half.

## Operation
- Reset values: pos_x = START_X, pos_y = START_Y, tick = 0, hit = 0, hit_lower = 0, divider = 0, state = MANUAL, dir_x = +, dir_y = +.
- Divider: counts 0..TICK_DIV−1 and wraps to 0. `tick` = 1 exactly when the count equals TICK_DIV−1.
- Clamp range: x ∈ [0, XMAX = SCREEN_W−OBJ_W], y ∈ [0, YMAX = SCREEN_H−OBJ_H].
- Arithmetic is done one bit wider and signed, so pos−STEP never underflows.
- State machine with states MANUAL and BOUNCE. On each tick, the state ← `mode`. A transition into BOUNCE sets dir_x and dir_y to +. The move on that tick uses the *new* state's rule.
- MANUAL move, per tick:
  - x ← clamp(x + STEP·(right − left)).
  - y ← clamp(y + STEP·(down − up)).
  - up+down both pressed → no vertical change; left+right both pressed → no horizontal change.
- BOUNCE move, per axis per tick: candidate = pos ± STEP according to dir.
  - If the candidate is outside [0, MAX]: pos ← the violated bound and dir inverts.
  - Otherwise pos ← candidate.
  - The two axes are independent.
  - Buttons are ignored.
- `freeze`=1 on a tick: no position or dir change; the state still updates.
- Hit logic:
  - hit = (pos_x ≤ curr_x < pos_x+OBJ_W) and (pos_y ≤ curr_y < pos_y+OBJ_H).
  - hit_lower = hit and curr_y ≥ pos_y + OBJ_H/2, using integer division.
  - The comparison is made against the pos value current in that cycle.

## Timing
- Position is updated in the tick cycle and is visible on `pos_*` the following cycle.
- `tick` is registered and high for 1 cycle every TICK_DIV cycles. The first tick comes TICK_DIV cycles after reset deasserts.
- `hit` and `hit_lower` have 1-cycle latency from `curr_x`/`curr_y`. There is no combinational path from any input to any output.
- `rst` asserted mid-tick or mid-bounce: next cycle all reset values apply; the divider restarts from 0.
- A button pulse that does not overlap a tick cycle is ignored (level-sampled only on ticks).

## Structure
- `game_pkg`:
  - `mode_t` enum {MANUAL, BOUNCE}.
  - Default screen constants SCREEN_W/SCREEN_H.
  - Clamp helper function shared with future sprite blocks.
- One sub-module `tick_gen`: parameter TICK_DIV; ports clk, rst, tick.
- Parameter-legality checks are elaboration-time assertions.

## Test plan
All scenarios use SCREEN 64×32, OBJ 8×4, STEP 2, TICK_DIV 4, START (10,10).
- Reset then idle 12 cycles → tick pulses on cycles 4, 8, 12; pos stays at (10,10); all outputs are at reset values during rst.
- MANUAL, hold left for 6 ticks → x = 8, 6, 4, 2, 0, 0. Then hold right+left together → x stays 0.
- MANUAL, hold down from y=26 → y = 28 (YMAX), then stays 28. Hold up+down together → no change.
- BOUNCE from (54,26) → x: 56, then 56 with dir inverted, then 54. y: 28, then 28, then 26.
- Sweep curr over the sprite at pos (10,10) → hit high for x 10..17 and y 10..13 one cycle later; hit_lower high only for y 12..13.
- Mode switch MANUAL→BOUNCE between ticks, then rst mid-run → switch happens only at the next tick with dir +,+; after rst, pos = (10,10) and state = MANUAL.
